// File: rtl/datapath_pkg.sv
// datapath_pkg -- shared widths and ALU operation encoding for the datapath.
//   DATA_W  : bus / register width
//   Z_W     : ALU result and Z register width
//   SH_W    : shift-amount width taken from B
//   NUM_OPS : number of one-hot ALU select lines
//   alu_op_e / alu_encode : priority encoding of the select lines
package datapath_pkg;

   localparam int DATA_W  = 32;
   localparam int Z_W     = 64;
   localparam int SH_W    = 5;
   localparam int NUM_OPS = 14;

   // Select-vector bit i maps to enum value i+1; OP_NONE means no select.
   typedef enum logic [3:0] {
      OP_NONE, OP_INCPC, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
      OP_SHL, OP_ROR, OP_ROL, OP_NEG, OP_NOT, OP_MUL, OP_DIV
   } alu_op_e;

   // Lowest select index wins (IncPC highest priority, DIV lowest).
   function automatic alu_op_e alu_encode(input logic [NUM_OPS-1:0] sel);
      alu_op_e op;
      op = OP_NONE;
      for (int i = NUM_OPS - 1; i >= 0; i--)
         if (sel[i]) op = alu_op_e'(4'(i + 1));
      return op;
   endfunction

endpackage

// File: rtl/datapath_alu.sv
// alu -- combinational ALU for the datapath.
//   a   : operand A (Y register)
//   b   : operand B (bus)
//   sel : one-hot-ish op selects {DIV,MUL,NOT,NEG,ROL,ROR,SHL,SHRA,SHR,OR,AND,SUB,ADD,IncPC}
//   c   : 64-bit result; high word only used by MUL (product) and DIV (remainder)
module alu
   import datapath_pkg::*;
(
   input  logic [DATA_W-1:0]  a,
   input  logic [DATA_W-1:0]  b,
   input  logic [NUM_OPS-1:0] sel,
   output logic [Z_W-1:0]     c
);

   alu_op_e                 op;
   logic [SH_W-1:0]         sh;
   logic [Z_W-1:0]          prod;
   logic [2*DATA_W-1:0]     ror_w, rol_w;
   logic [DATA_W-1:0]       sra, quot, rem;

   assign op    = alu_encode(sel);
   assign sh    = b[SH_W-1:0];
   assign prod  = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
   // Rotates via a doubled word: the spill-over bits land in the kept half.
   assign ror_w = {a, a} >> sh;
   assign rol_w = {a, a} << sh;
   assign sra   = $unsigned($signed(a) >>> sh);

   // Divide-by-zero gives 0; most-negative / -1 would overflow, so it wraps explicitly.
   always_comb begin
      quot = '0;
      rem  = '0;
      if (b == '0) begin
         quot = '0;
         rem  = '0;
      end else if (a == {1'b1, {(DATA_W-1){1'b0}}} && b == '1) begin
         quot = a;
         rem  = '0;
      end else begin
         quot = $unsigned($signed(a) / $signed(b));
         rem  = $unsigned($signed(a) % $signed(b));
      end
   end

   always_comb begin
      c = '0;
      case (op)
         OP_INCPC: c = {32'h0, b + 32'd1};
         OP_ADD:   c = {32'h0, a + b};
         OP_SUB:   c = {32'h0, a - b};
         OP_AND:   c = {32'h0, a & b};
         OP_OR:    c = {32'h0, a | b};
         OP_SHR:   c = {32'h0, a >> sh};
         OP_SHRA:  c = {32'h0, sra};
         OP_SHL:   c = {32'h0, a << sh};
         OP_ROR:   c = {32'h0, ror_w[DATA_W-1:0]};
         OP_ROL:   c = {32'h0, rol_w[2*DATA_W-1:DATA_W]};
         OP_NEG:   c = {32'h0, 32'h0 - b};
         OP_NOT:   c = {32'h0, ~b};
         OP_MUL:   c = prod;
         OP_DIV:   c = {rem, quot};
         default:  c = '0;
      endcase
   end

endmodule

// File: rtl/datapath.sv
// datapath -- bus-based CPU datapath driven entirely by external control lines.
//   clock, clear       : clock and synchronous active-high clear
//   R0in..R15in, ...in : register load enables (from bus; MDR from bus or Mdatain; Z from ALU)
//   R0out..R15out, ...out : bus source selects (priority R0 first, Cout last)
//   IncPC..DIV         : ALU op selects (A = Y, B = bus)
//   Read, Mdatain      : MDR source select and memory read data
//   R0..R15, HI, LO, PC_out, IR, MAR, Y, Z : register contents
//   BusMuxOut_signal   : current bus value
module datapath
   import datapath_pkg::*;
(
   input  logic        clock, clear,
   input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
   input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
   input  logic        HIin, LOin, PCin, IRin, Yin, MARin, MDRin, Zin,
   input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
   input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
   input  logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
   input  logic        IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV,
   input  logic        Read,
   input  logic [31:0] Mdatain,
   output logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7,
   output logic [31:0] R8, R9, R10, R11, R12, R13, R14, R15,
   output logic [31:0] HI, LO, PC_out, IR, MAR, Y,
   output logic [63:0] Z,
   output logic [31:0] BusMuxOut_signal
);

   logic [15:0]              r_in, r_out;
   logic [15:0][DATA_W-1:0]  r_q;
   logic [DATA_W-1:0]        hi_q, lo_q, pc_q, ir_q, mar_q, mdr_q, y_q, bus, c_sext;
   logic [Z_W-1:0]           z_q, alu_c;
   logic [NUM_OPS-1:0]       alu_sel;

   assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
   assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
   assign alu_sel = {DIV, MUL, NOT, NEG, ROL, ROR, SHL, SHRA, SHR, OR, AND, SUB, ADD, IncPC};
   assign c_sext  = {{13{ir_q[18]}}, ir_q[18:0]};

   // Later assignments override earlier ones, so the lowest-priority source is written first.
   always_comb begin
      bus = '0;
      if (Cout)      bus = c_sext;
      if (InPortout) bus = '0;
      if (MDRout)    bus = mdr_q;
      if (PCout)     bus = pc_q;
      if (Zlowout)   bus = z_q[31:0];
      if (Zhighout)  bus = z_q[63:32];
      if (LOout)     bus = lo_q;
      if (HIout)     bus = hi_q;
      for (int i = 15; i >= 0; i--)
         if (r_out[i]) bus = r_q[i];
   end

   alu u_alu (.a(y_q), .b(bus), .sel(alu_sel), .c(alu_c));

   always_ff @(posedge clock) begin
      if (clear) begin
         r_q   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         pc_q  <= '0;
         ir_q  <= '0;
         mar_q <= '0;
         mdr_q <= '0;
         y_q   <= '0;
         z_q   <= '0;
      end else begin
         for (int i = 0; i < 16; i++)
            if (r_in[i]) r_q[i] <= bus;
         if (HIin)  hi_q  <= bus;
         if (LOin)  lo_q  <= bus;
         if (PCin)  pc_q  <= bus;
         if (IRin)  ir_q  <= bus;
         if (MARin) mar_q <= bus;
         if (Yin)   y_q   <= bus;
         if (MDRin) mdr_q <= Read ? Mdatain : bus;
         if (Zin)   z_q   <= alu_c;
      end
   end

   assign R0  = r_q[0];   assign R1  = r_q[1];   assign R2  = r_q[2];   assign R3  = r_q[3];
   assign R4  = r_q[4];   assign R5  = r_q[5];   assign R6  = r_q[6];   assign R7  = r_q[7];
   assign R8  = r_q[8];   assign R9  = r_q[9];   assign R10 = r_q[10];  assign R11 = r_q[11];
   assign R12 = r_q[12];  assign R13 = r_q[13];  assign R14 = r_q[14];  assign R15 = r_q[15];
   assign HI  = hi_q;
   assign LO  = lo_q;
   assign PC_out = pc_q;
   assign IR  = ir_q;
   assign MAR = mar_q;
   assign Y   = y_q;
   assign Z   = z_q;
   assign BusMuxOut_signal = bus;

endmodule

// File: tb/tb_datapath.sv
// tb_datapath -- scoreboard bench for datapath: expectations are queued as each
// control step is driven and compared one clock later.
module tb_datapath;

   logic        clock = 1'b0;
   logic        clear;
   logic [15:0] rin, rout;
   logic        HIin, LOin, PCin, IRin, Yin, MARin, MDRin, Zin;
   logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout;
   logic [13:0] alu_sel;   // {DIV,MUL,NOT,NEG,ROL,ROR,SHL,SHRA,SHR,OR,AND,SUB,ADD,IncPC}
   logic        Read;
   logic [31:0] Mdatain;
   logic [31:0] r_obs [16];
   logic [31:0] hi, lo, pc, ir, mar, y, bus;
   logic [63:0] z;

   localparam int ID_HI = 16, ID_LO = 17, ID_PC = 18, ID_IR = 19, ID_MAR = 20,
                  ID_Y = 21, ID_Z = 22, ID_BUS = 23;
   localparam int OP_INC = 0, OP_ADD = 1, OP_SUB = 2, OP_AND = 3, OP_OR = 4, OP_SHR = 5,
                  OP_SHRA = 6, OP_SHL = 7, OP_ROR = 8, OP_ROL = 9, OP_NEG = 10,
                  OP_NOT = 11, OP_MUL = 12, OP_DIV = 13;

   always #5 clock = ~clock;

   datapath dut (
      .clock(clock), .clear(clear),
      .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
      .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
      .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
      .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
      .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Yin(Yin),
      .MARin(MARin), .MDRin(MDRin), .Zin(Zin),
      .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
      .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
      .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
      .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
      .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
      .PCout(PCout), .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout),
      .IncPC(alu_sel[0]), .ADD(alu_sel[1]), .SUB(alu_sel[2]), .AND(alu_sel[3]),
      .OR(alu_sel[4]), .SHR(alu_sel[5]), .SHRA(alu_sel[6]), .SHL(alu_sel[7]),
      .ROR(alu_sel[8]), .ROL(alu_sel[9]), .NEG(alu_sel[10]), .NOT(alu_sel[11]),
      .MUL(alu_sel[12]), .DIV(alu_sel[13]),
      .Read(Read), .Mdatain(Mdatain),
      .R0(r_obs[0]), .R1(r_obs[1]), .R2(r_obs[2]), .R3(r_obs[3]),
      .R4(r_obs[4]), .R5(r_obs[5]), .R6(r_obs[6]), .R7(r_obs[7]),
      .R8(r_obs[8]), .R9(r_obs[9]), .R10(r_obs[10]), .R11(r_obs[11]),
      .R12(r_obs[12]), .R13(r_obs[13]), .R14(r_obs[14]), .R15(r_obs[15]),
      .HI(hi), .LO(lo), .PC_out(pc), .IR(ir), .MAR(mar), .Y(y), .Z(z),
      .BusMuxOut_signal(bus)
   );

   typedef struct {
      string       tag;
      int          id;
      logic [63:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] observe(input int id);
      if (id < 16) return {32'h0, r_obs[id]};
      case (id)
         ID_HI:   return {32'h0, hi};
         ID_LO:   return {32'h0, lo};
         ID_PC:   return {32'h0, pc};
         ID_IR:   return {32'h0, ir};
         ID_MAR:  return {32'h0, mar};
         ID_Y:    return {32'h0, y};
         ID_Z:    return z;
         default: return {32'h0, bus};
      endcase
   endfunction

   task automatic expect_v(input string tag, input int id, input logic [63:0] e);
      sb.push_back('{tag, id, e});
   endtask

   // Immediate check of combinational state after inputs settle.
   task automatic now_chk(input string tag, input int id, input logic [63:0] e);
      #1;
      chk(tag, observe(id), e);
   endtask

   task automatic idle();
      clear = 0; rin = '0; rout = '0; alu_sel = '0; Read = 0; Mdatain = '0;
      HIin = 0; LOin = 0; PCin = 0; IRin = 0; Yin = 0; MARin = 0; MDRin = 0; Zin = 0;
      HIout = 0; LOout = 0; Zhighout = 0; Zlowout = 0; PCout = 0; MDRout = 0;
      InPortout = 0; Cout = 0;
   endtask

   task automatic step();
      exp_t e;
      @(posedge clock);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.tag, observe(e.id), e.exp);
      end
      idle();
   endtask

   task automatic load_mdr(input logic [31:0] v);
      Read = 1; MDRin = 1; Mdatain = v;
      step();
   endtask

   task automatic load_y(input logic [31:0] v);
      load_mdr(v);
      MDRout = 1; Yin = 1;
      step();
   endtask

   task automatic alu_run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input int op, input logic [63:0] e);
      load_y(av);
      load_mdr(bv);
      MDRout = 1; alu_sel[op] = 1'b1; Zin = 1;
      expect_v(tag, ID_Z, e);
      step();
   endtask

   initial begin
      idle();
      // Clear everything
      clear = 1;
      for (int i = 0; i < 16; i++) expect_v($sformatf("clr_r%0d", i), i, 64'h0);
      expect_v("clr_hi", ID_HI, 0);  expect_v("clr_lo", ID_LO, 0);
      expect_v("clr_pc", ID_PC, 0);  expect_v("clr_ir", ID_IR, 0);
      expect_v("clr_mar", ID_MAR, 0); expect_v("clr_y", ID_Y, 0);
      expect_v("clr_z", ID_Z, 0);
      step();

      // Memory -> MDR -> R5, R6
      load_mdr(32'h34);
      MDRout = 1; rin[5] = 1;
      now_chk("bus_mdr", ID_BUS, 64'h34);
      expect_v("r5_load", 5, 64'h34);
      step();
      load_mdr(32'h45);
      MDRout = 1; rin[6] = 1;
      expect_v("r6_load", 6, 64'h45);
      step();

      // R2 = R5 + R6
      rout[5] = 1; Yin = 1;
      expect_v("y_r5", ID_Y, 64'h34);
      step();
      rout[6] = 1; alu_sel[OP_ADD] = 1; Zin = 1;
      expect_v("z_add", ID_Z, 64'h79);
      step();
      Zlowout = 1; rin[2] = 1;
      expect_v("r2_add", 2, 64'h79);
      step();

      // Instruction fetch
      PCout = 1; MARin = 1; alu_sel[OP_INC] = 1; Zin = 1;
      expect_v("mar_pc", ID_MAR, 64'h0);
      expect_v("z_incpc", ID_Z, 64'h1);
      step();
      Zlowout = 1; PCin = 1;
      expect_v("pc_inc", ID_PC, 64'h1);
      step();
      load_mdr(32'h112B0000);
      MDRout = 1; IRin = 1;
      expect_v("ir_load", ID_IR, 64'h112B0000);
      step();
      Cout = 1;
      now_chk("cout_pos", ID_BUS, 64'h00030000);
      idle();
      load_mdr(32'h0007FFFF);
      MDRout = 1; IRin = 1;
      step();
      Cout = 1; rin[8] = 1;
      expect_v("cout_neg", 8, 64'hFFFFFFFF);
      step();

      // ALU operations
      alu_run("mul",      32'hFFFFFFFE, 32'd3, OP_MUL, 64'hFFFFFFFF_FFFFFFFA);
      Zhighout = 1; rin[7] = 1;
      expect_v("zhigh_r7", 7, 64'hFFFFFFFF);
      step();
      alu_run("div",      32'd7,        32'd2, OP_DIV, 64'h00000001_00000003);
      alu_run("div_neg",  32'hFFFFFFF9, 32'd2, OP_DIV, 64'hFFFFFFFF_FFFFFFFD);
      alu_run("div0",     32'd7,        32'd0, OP_DIV, 64'h0);
      alu_run("shra",     32'h80000001, 32'd1, OP_SHRA, 64'hC0000000);
      alu_run("shr",      32'h80000001, 32'd1, OP_SHR,  64'h40000000);
      alu_run("ror",      32'h80000001, 32'd1, OP_ROR,  64'hC0000000);
      alu_run("rol",      32'h80000001, 32'd1, OP_ROL,  64'h00000003);
      alu_run("shl_wrap", 32'h80000001, 32'd33, OP_SHL, 64'h00000002);
      alu_run("sub",      32'd5,        32'd7, OP_SUB, 64'hFFFFFFFE);
      alu_run("and",      32'hF0F0FFFF, 32'h0FF0F00F, OP_AND, 64'h00F0F00F);
      alu_run("or",       32'hF0000000, 32'h0000000F, OP_OR,  64'hF000000F);
      alu_run("neg",      32'd9,        32'd1, OP_NEG, 64'hFFFFFFFF);
      alu_run("not",      32'd9,        32'h0000FFFF, OP_NOT, 64'hFFFF0000);
      alu_run("add_wrap", 32'hFFFFFFFF, 32'd2, OP_ADD, 64'h1);

      // ADD beats SUB when both asserted; no select gives 0
      load_y(32'd5);
      load_mdr(32'd7);
      MDRout = 1; alu_sel[OP_ADD] = 1; alu_sel[OP_SUB] = 1; Zin = 1;
      expect_v("prio_add", ID_Z, 64'd12);
      step();
      MDRout = 1; Zin = 1;
      expect_v("no_op", ID_Z, 64'h0);
      step();

      // HI / LO loads, and R0 out beats R2 out
      rout[2] = 1; HIin = 1;
      expect_v("hi_load", ID_HI, 64'h79);
      step();
      rout[0] = 1; rout[2] = 1; LOin = 1;
      expect_v("bus_prio", ID_LO, 64'h0);
      step();

      // Same-cycle write and read: old value on bus, new after edge
      load_mdr(32'hAAAA0001);
      MDRout = 1; MDRin = 1; Read = 1; Mdatain = 32'h5555_0002;
      now_chk("rw_old", ID_BUS, 64'hAAAA0001);
      step();
      MDRout = 1;
      now_chk("rw_new", ID_BUS, 64'h55550002);
      idle();

      // Clear overrides load enables
      clear = 1; rin[5] = 1; MDRout = 1;
      expect_v("clr_over", 5, 64'h0);
      expect_v("clr_r2", 2, 64'h0);
      step();
      now_chk("bus_none", ID_BUS, 64'h0);
      MDRout = 1;
      now_chk("clr_mdr", ID_BUS, 64'h0);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
